adder_tree_accum_ctrl: RTL

- Sequencing controller that reduces long unsigned vectors through one shared, combinational adder_tree instance (N lanes wide).
- Each vector arrives as 1..MAXB beats of N lanes over a valid/ready stream. The controller sums each beat through the tree and accumulates the partial sums into a wide register.
- It presents the final total on a valid/ready result port.
- Used ahead of neuron membrane-potential update logic, where fan-in exceeds the tree width.

---
 rtl/adder_tree_accum_ctrl_if.sv | 40 ++++
 rtl/adder_tree_accum_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_accum_ctrl_if.sv
// rtl/adder_tree_accum_ctrl_if.sv - beat input and result output bundle for adder_tree_accum_ctrl
//
// Purpose: groups the configuration, input beat stream and result stream of
// the accumulation controller.
// Signals:
//   cfg_beats  beats in the next vector (sampled on the first beat only)
//   in_valid / in_ready / in_data / in_last   input beat stream, lane i at [i*W +: W]
//   out_valid / out_ready / out_sum / out_err result stream
// Modports: master = producer/consumer side, slave = controller side.

interface adder_tree_accum_ctrl_if #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int MAXB = 16
);
  localparam int A  = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int BW = ($clog2(MAXB) > 0) ? $clog2(MAXB) : 1;
  localparam int SW = W + A + BW;
  localparam int CW = $clog2(MAXB + 1);

  logic [CW-1:0]  cfg_beats;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sum;
  logic           out_err;

  modport master (
    output cfg_beats, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_err
  );

  modport slave (
    input  cfg_beats, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/adder_tree_accum_ctrl.sv
// rtl/adder_tree_accum_ctrl.sv - beat-serial vector reduction through one shared adder tree
//
// Purpose: sums each N-lane beat with a combinational adder tree and
// accumulates 1..MAXB beats per vector into a wide total, then presents the
// total on a valid/ready result port.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      adder_tree_accum_ctrl_if.slave (cfg_beats, in_* beat stream, out_* result)
// Optional: define ADDER_TREE_ACCUM_PIPE_EN to register the tree output; a
// DRAIN state then folds the last registered partial before DONE.

module adder_tree #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int A = 3
) (
  input  logic [N*W-1:0] data,
  output logic [W+A-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + (W+A)'(data[i*W +: W]);
    end
  end
endmodule

module adder_tree_accum_ctrl #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int MAXB = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  adder_tree_accum_ctrl_if.slave bus
);
  localparam int A  = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int BW = ($clog2(MAXB) > 0) ? $clog2(MAXB) : 1;
  localparam int SW = W + A + BW;
  localparam int CW = $clog2(MAXB + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

`ifdef ADDER_TREE_ACCUM_PIPE_EN
  localparam state_t S_LAST = S_DRAIN;
`else
  localparam state_t S_LAST = S_DONE;
`endif

  state_t         state_q, state_d;
  logic [CW-1:0]  beats_q, beats_d, cnt_q, cnt_d, eff_beats, cnt_inc;
  logic           err_q, err_d;
  logic [SW-1:0]  acc_q, acc_d, tree_ext, addend;
  logic [W+A-1:0] tree_sum;
  logic           rdy_c, vld_c, accept, final_beat, acc_clr;

  adder_tree #(.N(N), .W(W), .A(A)) u_tree (
    .data (bus.in_data),
    .sum  (tree_sum)
  );

  assign tree_ext = SW'(tree_sum);

  // Zero beats means one; anything past MAXB is clamped.
  always_comb begin
    eff_beats = bus.cfg_beats;
    if (bus.cfg_beats == '0) begin
      eff_beats = CW'(1);
    end else if (bus.cfg_beats > CW'(MAXB)) begin
      eff_beats = CW'(MAXB);
    end
  end

  assign cnt_inc    = cnt_q + CW'(1);
  assign final_beat = (cnt_inc == beats_q);
  assign accept     = bus.in_valid && rdy_c && reset_n;

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    acc_clr = 1'b0;
    rdy_c   = 1'b0;
    vld_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_c = 1'b1;
        if (accept) begin
          beats_d = eff_beats;
          cnt_d   = CW'(1);
          err_d   = (bus.in_last != (eff_beats == CW'(1)));
          state_d = (bus.in_last || eff_beats == CW'(1)) ? S_LAST : S_ACCUM;
        end
      end
      S_ACCUM: begin
        rdy_c = 1'b1;
        if (accept) begin
          cnt_d = cnt_inc;
          if (bus.in_last != final_beat) begin
            err_d = 1'b1;
          end
          if (bus.in_last || final_beat) begin
            state_d = S_LAST;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        vld_c = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b0;
          acc_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ADDER_TREE_ACCUM_PIPE_EN
  logic [SW-1:0] pipe_q;
  logic          pipe_v;

  // Partial is folded into the accumulator the cycle after its beat lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
      pipe_v <= 1'b0;
    end else begin
      pipe_v <= accept;
      if (accept) begin
        pipe_q <= tree_ext;
      end
    end
  end

  assign addend = pipe_v ? pipe_q : '0;
`else
  assign addend = accept ? tree_ext : '0;
`endif

  // IDLE starts a fresh total; acc is already zero there, so this only
  // guards against stale state.
  always_comb begin
    acc_d = (state_q == S_IDLE) ? addend : acc_q + addend;
    if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = rdy_c && reset_n;
  assign bus.out_valid = vld_c;
  assign bus.out_sum   = vld_c ? acc_q : '0;
  assign bus.out_err   = vld_c && err_q;
endmodule
